math_challenge: RTL and testbench
=================================

# math_challenge

Alarm-dismissal stage that sits directly downstream of the alarm block. It consumes the `alarm` level and presents the user with a pseudo-random arithmetic problem (add or multiply, single-digit operands). It accepts an answer from switches plus a submit key. On a correct answer it drives `alarm_off` back to the alarm block, holding it until the alarm actually drops.

## Interface
- `SEED`, default 8'hA5: LFSR reset value; 8'h00 is replaced by 8'h01.
- `clock` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `alarm` in 1: alarm level from the alarm block.
- `ans_sw` in 7: user answer, unsigned binary, 0..127.
- `ans_key` in 1: submit key, active-high, level while held.
- `op_a` out 4: first operand, 0..9.
- `op_b` out 4: second operand, 0..9.
- `op_mul` out 1: 1 = multiply, 0 = add.
- `challenge_active` out 1: problem displayed, answer awaited.
- `alarm_off` out 1: dismissal level to the alarm block.
- `wrong_count` out 4: wrong answers this alarm, saturating at 15.

## Operation
- **LFSR:** 8-bit, free-running every cycle in all states. Shift left, new bit0 = l[7]^l[5]^l[4]^l[3].
- **Operand mapping:**
  - `op_a` = l[3:0], minus 10 if ≥10.
  - `op_b` = l[7:4], minus 10 if ≥10.
  - `op_mul` = l[4]^l[0].
- **Expected answer:** 7-bit register, a+b (max 18) or a*b (max 81), computed in LOAD.
- **IDLE:** all outputs 0 except `wrong_count`, which holds. On `alarm`=1: clear `wrong_count`, go to LOAD.
- **LOAD** (1 cycle): latch `op_a`, `op_b`, `op_mul` from the current LFSR and compute the expected answer. Go to ASK.
- **ASK:**
  - `challenge_active`=1.
  - `ans_key`=1 → HELD.
- **HELD:** on `ans_key`=0 (release), capture `ans_sw` into the answer register → CHECK. One submission per press; holding the key never resubmits.
- **CHECK** (1 cycle):
  - answer == expected → DISMISS.
  - else `wrong_count`+1 (saturate at 15) → LOAD, giving a fresh problem from the current LFSR.
- **DISMISS:**
  - `alarm_off`=1, `challenge_active`=0.
  - Hold until `alarm`=0, then → IDLE.
- **Abort:** `alarm`=0 while in LOAD, ASK, HELD or CHECK → IDLE. Operands are zeroed; `wrong_count` is kept.
- **Reset:**
  - state IDLE, LFSR=`SEED`.
  - `op_a`/`op_b`/`op_mul`/`challenge_active`/`alarm_off`/`wrong_count` = 0.
  - Reset mid-challenge discards the problem and answer.
- **Operand registers:** all operand, answer and expected-answer registers are unsigned. Comparison uses the full 7 bits; `ans_sw` values above 81 are simply wrong.

## Timing
- All outputs are registered; no combinational input→output path.
- `alarm` rises, sampled at edge t:
  - LOAD at t+1.
  - `op_a`/`op_b`/`op_mul` and `challenge_active` valid at t+2.
- `ans_key` release, sampled at edge r:
  - CHECK at r+1.
  - Correct: `alarm_off`=1 and `challenge_active`=0 from r+2.
  - Wrong: `wrong_count` increments at r+2 and new operands are valid at r+3.
- `alarm_off` stays high while `alarm`=1. This covers the alarm block holding `alarm` until the minute no longer matches. `alarm_off` falls the cycle after `alarm`=0 is sampled.
- Press and release of `ans_key` in consecutive cycles is accepted (minimum HELD dwell of 1 cycle).
- Press during LOAD or CHECK is ignored until ASK is reached.
- `alarm` re-asserting on the same edge that DISMISS→IDLE is taken: IDLE sees it on the next edge and starts a new challenge.
- Reset assertion clears outputs asynchronously. Deassertion is synchronous to the next `clock` edge.

## Test plan
- Reset with `SEED`=8'h00 → LFSR=8'h01; all outputs 0. After 255 cycles the LFSR returns to 8'h01, never 8'h00.
- `alarm`=1 → at t+2, `challenge_active`=1 with `op_a`,`op_b`≤9. Bench model computes the answer, e.g. 7,8,mul → 56. Press/release `ans_key` with `ans_sw`=56 → `alarm_off`=1 at r+2; drop `alarm` → `alarm_off`=0 one cycle later, state IDLE.
- Wrong answer (expected+1) → `wrong_count`=1 at r+2 and new operands at r+3. Repeat 16 wrong answers → `wrong_count` saturates at 15. Correct answer → `alarm_off`=1.
- Hold `ans_key` high 100 cycles with a correct `ans_sw` → no CHECK until release; exactly one submission.
- `alarm` drops while in HELD → IDLE next cycle, `challenge_active`=0, `alarm_off` never asserted. Next `alarm` rise clears `wrong_count`.
- `reset` pulsed low mid-ASK → all outputs 0 immediately, without a clock edge. After release, `alarm`=1 starts a fresh challenge with the LFSR restarted from `SEED`.

Source files
------------

// File: rtl/math_challenge.sv
`default_nettype none
// ============================================================================
// math_challenge : alarm dismissal by solving a single-digit add/mul problem
// Revision 1.0
// ============================================================================
module math_challenge #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       alarm,
    input  logic [6:0] ans_sw,
    input  logic       ans_key,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       op_mul,
    output logic       challenge_active,
    output logic       alarm_off,
    output logic [3:0] wrong_count
);

    // An all-zero LFSR would lock up, so that seed is remapped.
    localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ASK     = 3'd2,
        HELD    = 3'd3,
        CHECK   = 3'd4,
        DISMISS = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [6:0] answer;
    logic [6:0] expected;
    logic [3:0] lfsr_a;
    logic [3:0] lfsr_b;
    logic       lfsr_mul;
    logic [6:0] sum;
    logic [6:0] product;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_INIT;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_comb begin
        lfsr_a   = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];
        lfsr_b   = (lfsr[7:4] >= 4'd10) ? lfsr[7:4] - 4'd10 : lfsr[7:4];
        lfsr_mul = lfsr[4] ^ lfsr[0];
        sum      = {3'b000, lfsr_a} + {3'b000, lfsr_b};
        product  = {3'b000, lfsr_a} * {3'b000, lfsr_b};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping the alarm aborts any unfinished challenge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (alarm) state_nxt = LOAD;
            LOAD:    state_nxt = alarm ? ASK : IDLE;
            ASK: begin
                if (!alarm)       state_nxt = IDLE;
                else if (ans_key) state_nxt = HELD;
            end
            HELD: begin
                if (!alarm)        state_nxt = IDLE;
                else if (!ans_key) state_nxt = CHECK;
            end
            CHECK: begin
                if (!alarm)                  state_nxt = IDLE;
                else if (answer == expected) state_nxt = DISMISS;
                else                         state_nxt = LOAD;
            end
            DISMISS: if (!alarm) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_a     <= 4'd0;
            op_b     <= 4'd0;
            op_mul   <= 1'b0;
            expected <= 7'd0;
            answer   <= 7'd0;
        end else begin
            if (state_nxt == IDLE) begin
                op_a     <= 4'd0;
                op_b     <= 4'd0;
                op_mul   <= 1'b0;
                expected <= 7'd0;
                answer   <= 7'd0;
            end else if (state == LOAD) begin
                op_a     <= lfsr_a;
                op_b     <= lfsr_b;
                op_mul   <= lfsr_mul;
                expected <= lfsr_mul ? product : sum;
            end else if (state == HELD && state_nxt == CHECK) begin
                answer <= ans_sw;
            end
        end
    end

    // The problem stays displayed while a retry is being loaded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            challenge_active <= 1'b0;
            alarm_off        <= 1'b0;
        end else begin
            challenge_active <= (state_nxt inside {ASK, HELD, CHECK}) ||
                                ((state_nxt == LOAD) && challenge_active);
            alarm_off        <= (state_nxt == DISMISS);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrong_count <= 4'd0;
        end else if (state == IDLE && alarm) begin
            wrong_count <= 4'd0;
        end else if (state == CHECK && state_nxt == LOAD && wrong_count != 4'd15) begin
            wrong_count <= wrong_count + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_math_challenge.sv
`default_nettype none
// ============================================================================
// tb_math_challenge : randomized scoreboard bench for math_challenge
// Revision 1.0
// ============================================================================
module tb_math_challenge;

    localparam logic [7:0] TB_SEED  = 8'h00;
    localparam logic [7:0] SEED_EFF = (TB_SEED == 8'h00) ? 8'h01 : TB_SEED;

    localparam logic [3:0] M_OPS  = 4'b0001;
    localparam logic [3:0] M_CA   = 4'b0010;
    localparam logic [3:0] M_AOFF = 4'b0100;
    localparam logic [3:0] M_WC   = 4'b1000;
    localparam logic [3:0] M_ALL  = 4'b1111;

    localparam int T_IDLE = 0, T_START = 1, T_HOLD = 2, T_OK = 3,
                   T_WRONG = 4, T_NEWOP = 5, T_DISMISS = 6, T_ABORT = 7;

    logic       clock = 1'b0;
    logic       reset;
    logic       alarm = 1'b0;
    logic [6:0] ans_sw = 7'd0;
    logic       ans_key = 1'b0;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_mul;
    logic       challenge_active;
    logic       alarm_off;
    logic [3:0] wrong_count;

    math_challenge #(.SEED(TB_SEED)) dut (
        .clock            (clock),
        .reset            (reset),
        .alarm            (alarm),
        .ans_sw           (ans_sw),
        .ans_key          (ans_key),
        .op_a             (op_a),
        .op_b             (op_b),
        .op_mul           (op_mul),
        .challenge_active (challenge_active),
        .alarm_off        (alarm_off),
        .wrong_count      (wrong_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        int         a;
        int         b;
        int         mul;
        int         ca;
        int         aoff;
        int         wc;
        int         tag;
    } rec_t;

    rec_t sb[$];
    rec_t mon_r;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] m_lfsr;

    int cur_a, cur_b, cur_mul, cur_exp, wc_m;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic string tag_name(input int t);
        case (t)
            T_IDLE:    return "idle";
            T_START:   return "start";
            T_HOLD:    return "hold";
            T_OK:      return "correct";
            T_WRONG:   return "wrong";
            T_NEWOP:   return "retry";
            T_DISMISS: return "dismiss";
            T_ABORT:   return "abort";
            default:   return "rec";
        endcase
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Reference LFSR: the sequence the operands must follow.
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= SEED_EFF;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] m, input int a, input int b,
                        input int mul, input int ca, input int aoff, input int wc,
                        input int tag);
        rec_t r;
        r.cyc = c; r.mask = m; r.a = a; r.b = b; r.mul = mul;
        r.ca = ca; r.aoff = aoff; r.wc = wc; r.tag = tag;
        sb.push_back(r);
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_r = sb.pop_front();
            if (mon_r.cyc < cyc) begin
                chk({tag_name(mon_r.tag), " stale_record_cycle"}, cyc, mon_r.cyc);
            end else begin
                if (mon_r.mask[0]) begin
                    chk({tag_name(mon_r.tag), " op_a"}, int'(op_a), mon_r.a);
                    chk({tag_name(mon_r.tag), " op_b"}, int'(op_b), mon_r.b);
                    chk({tag_name(mon_r.tag), " op_mul"}, int'(op_mul), mon_r.mul);
                end
                if (mon_r.mask[1]) chk({tag_name(mon_r.tag), " challenge_active"},
                                       int'(challenge_active), mon_r.ca);
                if (mon_r.mask[2]) chk({tag_name(mon_r.tag), " alarm_off"},
                                       int'(alarm_off), mon_r.aoff);
                if (mon_r.mask[3]) chk({tag_name(mon_r.tag), " wrong_count"},
                                       int'(wrong_count), mon_r.wc);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic new_problem(input logic [7:0] l);
        cur_a   = int'(l[3:0]) % 10;
        cur_b   = int'(l[7:4]) % 10;
        cur_mul = int'(l[4] ^ l[0]);
        cur_exp = (cur_mul != 0) ? cur_a * cur_b : cur_a + cur_b;
    endtask

    task automatic start_alarm();
        logic [7:0] l;
        l = lfsr_step(m_lfsr);
        alarm = 1'b1;
        wc_m = 0;
        new_problem(l);
        push(cyc + 1, M_WC, 0, 0, 0, 0, 0, 0, T_START);
        push(cyc + 2, M_ALL, cur_a, cur_b, cur_mul, 1, 0, 0, T_START);
        tick();
        tick();
    endtask

    function automatic int wrong_val();
        int v;
        v = int'($urandom_range(0, 127));
        if (v == cur_exp) v = (v + 1) % 128;
        return v;
    endfunction

    // Press with a decoy value; the real answer is only present at release.
    task automatic submit(input int val, input int hold);
        int m;
        int r;
        logic [7:0] l;
        m = cyc;
        ans_sw  = 7'(val) ^ 7'h2A;
        ans_key = 1'b1;
        if (hold > 4) push(m + hold / 2, M_CA | M_AOFF | M_WC, 0, 0, 0, 1, 0, wc_m, T_HOLD);
        repeat (hold) tick();
        r = cyc;
        ans_sw  = 7'(val);
        ans_key = 1'b0;
        if (val == cur_exp) begin
            push(r + 2, M_CA | M_AOFF | M_WC, 0, 0, 0, 0, 1, wc_m, T_OK);
            tick();
            tick();
        end else begin
            l = lfsr_step(lfsr_step(m_lfsr));
            if (wc_m < 15) wc_m++;
            push(r + 2, M_AOFF | M_WC, 0, 0, 0, 0, 0, wc_m, T_WRONG);
            new_problem(l);
            push(r + 3, M_ALL, cur_a, cur_b, cur_mul, 1, 0, wc_m, T_NEWOP);
            tick();
            tick();
            tick();
        end
    endtask

    task automatic dismiss_drop(input int extra);
        for (int k = 1; k <= extra; k++)
            push(cyc + k, M_CA | M_AOFF, 0, 0, 0, 0, 1, 0, T_DISMISS);
        repeat (extra) tick();
        alarm = 1'b0;
        push(cyc + 1, M_ALL, 0, 0, 0, 0, 0, wc_m, T_IDLE);
        tick();
    endtask

    task automatic abort_in_held();
        ans_sw  = 7'(cur_exp);
        ans_key = 1'b1;
        tick();
        alarm = 1'b0;
        for (int k = 1; k <= 3; k++)
            push(cyc + k, M_ALL, 0, 0, 0, 0, 0, wc_m, T_ABORT);
        tick();
        ans_key = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("reset op_a", int'(op_a), 0);
        chk("reset op_b", int'(op_b), 0);
        chk("reset op_mul", int'(op_mul), 0);
        chk("reset challenge_active", int'(challenge_active), 0);
        chk("reset alarm_off", int'(alarm_off), 0);
        chk("reset wrong_count", int'(wrong_count), 0);
        tick();
        tick();
        reset = 1'b1;
        wc_m = 0;
        push(cyc + 1, M_ALL, 0, 0, 0, 0, 0, 0, T_IDLE);
        push(cyc + 2, M_ALL, 0, 0, 0, 0, 0, 0, T_IDLE);
        repeat (3) tick();

        // Straight correct answer
        start_alarm();
        submit(cur_exp, 1);
        dismiss_drop(2);

        // Sixteen wrong answers saturate the counter, then solve
        repeat (2) tick();
        start_alarm();
        submit(cur_exp + 1, 1);
        for (int i = 0; i < 15; i++) submit(wrong_val(), int'($urandom_range(1, 3)));
        submit(cur_exp, 2);
        dismiss_drop(0);

        // Key held for 100 cycles gives exactly one submission
        tick();
        start_alarm();
        submit(cur_exp, 100);
        dismiss_drop(1);

        // Abort while held, then a new alarm clears the wrong count
        tick();
        start_alarm();
        submit(wrong_val(), 1);
        abort_in_held();
        start_alarm();
        submit(cur_exp, 1);
        dismiss_drop(0);

        for (int rnd = 0; rnd < 25; rnd++) begin
            int nw;
            repeat ($urandom_range(0, 20)) tick();
            start_alarm();
            nw = int'($urandom_range(0, 3));
            for (int i = 0; i < nw; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                submit(wrong_val(), int'($urandom_range(1, 6)));
            end
            repeat ($urandom_range(0, 3)) tick();
            submit(cur_exp, int'($urandom_range(1, 6)));
            dismiss_drop(int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a challenge
        tick();
        start_alarm();
        submit(wrong_val(), 1);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("midreset op_a", int'(op_a), 0);
        chk("midreset op_b", int'(op_b), 0);
        chk("midreset op_mul", int'(op_mul), 0);
        chk("midreset challenge_active", int'(challenge_active), 0);
        chk("midreset alarm_off", int'(alarm_off), 0);
        chk("midreset wrong_count", int'(wrong_count), 0);
        alarm = 1'b0;
        tick();
        reset = 1'b1;
        wc_m = 0;
        tick();
        start_alarm();
        submit(cur_exp, 1);
        dismiss_drop(0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d records left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
